usr_seq_ctrl: RTL and testbench

Command-driven sequencer for the 4-bit `universal_shift_reg` datapath. It accepts one command at a time over a valid/ready handshake and drives the register's `sel`, `pin`, `slin` and `srin` inputs for the required number of cycles. It also streams serial bits in and out and signals completion. It sits between a host or bus adapter and one `universal_shift_reg` instance, turning that register into a serializer/deserializer.

---
 rtl/usr_seq_ctrl_pkg.sv | 27 ++
 rtl/usr_seq_ctrl_if.sv | 16 +
 rtl/universal_shift_reg.sv | 22 ++
 rtl/usr_shift_counter.sv | 28 ++
 rtl/usr_seq_ctrl.sv | 105 ++++++++++
 tb/tb_usr_seq_ctrl.sv | 183 ++++++++++++++++++
 6 files changed

// File: rtl/usr_seq_ctrl_pkg.sv
// usr_ctrl_pkg: shared constants for the universal_shift_reg sequencer.
//   Opcodes carried on the command interface, datapath sel encodings and
//   the controller FSM state type.
package usr_ctrl_pkg;

  localparam logic [1:0] OP_LOAD     = 2'b00;
  localparam logic [1:0] OP_SHR      = 2'b01;
  localparam logic [1:0] OP_SHL      = 2'b10;
  localparam logic [1:0] OP_LOAD_SHR = 2'b11;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic is_load_op(input logic [1:0] op);
    return (op == OP_LOAD) || (op == OP_LOAD_SHR);
  endfunction

endpackage

// File: rtl/usr_seq_ctrl_if.sv
// usr_seq_ctrl_if: command valid/ready channel into the sequencer.
//   master : host side (drives valid/op/cnt/data, sees ready)
//   slave  : controller side
interface usr_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, cmd_op, cmd_cnt, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_cnt, cmd_data, output cmd_ready);
endinterface

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: 4-function register datapath (no reset).
//   sel_i 00 hold, 01 shift right (MSB<-srin_i), 10 shift left (LSB<-slin_i),
//   11 parallel load from pin_i; pout_o is the register value.
module universal_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic [1:0]       sel_i,
  input  logic [WIDTH-1:0] pin_i,
  input  logic             slin_i,
  input  logic             srin_i,
  output logic [WIDTH-1:0] pout_o
);
  always_ff @(posedge clk) begin
    case (sel_i)
      2'b01:   pout_o <= {srin_i, pout_o[WIDTH-1:1]};
      2'b10:   pout_o <= {pout_o[WIDTH-2:0], slin_i};
      2'b11:   pout_o <= pin_i;
      default: pout_o <= pout_o;
    endcase
  end
endmodule

// File: rtl/usr_shift_counter.sv
// usr_shift_counter: loadable down-counter for the remaining shift cycles.
//   load_i/load_val_i : load a new count (wins over dec_i)
//   dec_i             : decrement; saturates at zero
//   last_o            : count == 1, zero_o : count == 0
module usr_shift_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt_q <= '0;
    else if (load_i)           cnt_q <= load_val_i;
    else if (dec_i && !zero_o) cnt_q <= cnt_q - 1'b1;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/usr_seq_ctrl.sv
// usr_seq_ctrl: command sequencer for universal_shift_reg.
//   cmd       : valid/ready command channel (op, shift count, load data)
//   abort_i   : end the active LOAD/SHIFT after the current cycle, err_o=1
//   ser_i/o   : serial stream in/out, ser_valid_o marks each shift cycle
//   sel_o, pin_o, slin_o, srin_o : datapath controls; pout_i : datapath value
//   done_o/err_o : one-cycle completion pulse and abort status
module usr_seq_ctrl
  import usr_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n_i,
  usr_seq_ctrl_if.slave    cmd,
  input  logic             abort_i,
  input  logic             ser_i,
  output logic             ser_o,
  output logic             ser_valid_o,
  output logic [1:0]       sel_o,
  output logic [WIDTH-1:0] pin_o,
  output logic             slin_o,
  output logic             srin_o,
  input  logic [WIDTH-1:0] pout_i,
  output logic             done_o,
  output logic             err_o
);
  state_e           state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic             err_q;
  logic             hs, busy, shifting, right;
  logic             cnt_last, cnt_zero;
  logic [CNT_W-1:0] cnt_unused;

  assign hs       = (state_q == ST_IDLE) && cmd.cmd_valid;
  assign busy     = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign shifting = (state_q == ST_SHIFT);
  assign right    = (op_q != OP_SHL);

  usr_shift_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n_i),
    .load_i     (hs),
    .load_val_i (cmd.cmd_cnt),
    .dec_i      (shifting),
    .cnt_o      (cnt_unused),
    .last_o     (cnt_last),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        op_q   <= cmd.cmd_op;
        data_q <= cmd.cmd_data;
        err_q  <= 1'b0;
      end else if (busy && abort_i) begin
        err_q  <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      // The counter is loaded by this same edge, so a zero count is
      // judged from the command itself.
      ST_IDLE:
        if (cmd.cmd_valid) begin
          if (is_load_op(cmd.cmd_op))  state_d = ST_LOAD;
          else if (cmd.cmd_cnt == '0)  state_d = ST_DONE;
          else                         state_d = ST_SHIFT;
        end
      ST_LOAD:
        if (abort_i || op_q != OP_LOAD_SHR || cnt_zero) state_d = ST_DONE;
        else                                            state_d = ST_SHIFT;
      ST_SHIFT:
        if (abort_i || cnt_last) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd.cmd_ready = (state_q == ST_IDLE);
    done_o        = (state_q == ST_DONE);
    err_o         = (state_q == ST_DONE) && err_q;
    ser_valid_o   = shifting;
    pin_o         = (state_q == ST_LOAD) ? data_q : '0;
    sel_o         = SEL_HOLD;
    if (state_q == ST_LOAD) sel_o = SEL_LOAD;
    else if (shifting)      sel_o = right ? SEL_SHR : SEL_SHL;
    // Serial path is combinational through ser_i/pout_i so the bit in and
    // the bit out line up with the shift happening this cycle.
    srin_o = shifting &&  right && ser_i;
    slin_o = shifting && !right && ser_i;
    ser_o  = shifting && (right ? pout_i[0] : pout_i[WIDTH-1]);
  end
endmodule

// File: tb/tb_usr_seq_ctrl.sv
module tb_usr_seq_ctrl;
  import usr_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       abort, ser_in, ser_out, ser_valid, slin, srin, done, err;
  logic [1:0] sel;
  logic [3:0] pin, pout;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [3:0] mv;  // reference model of the register contents

  usr_seq_ctrl_if #(.WIDTH(4), .CNT_W(3)) cif ();

  usr_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n_i(rst_n), .cmd(cif), .abort_i(abort), .ser_i(ser_in),
    .ser_o(ser_out), .ser_valid_o(ser_valid), .sel_o(sel), .pin_o(pin),
    .slin_o(slin), .srin_o(srin), .pout_i(pout), .done_o(done), .err_o(err)
  );

  universal_shift_reg #(.WIDTH(4)) u_dp (
    .clk(clk), .sel_i(sel), .pin_i(pin), .slin_i(slin), .srin_i(srin), .pout_o(pout)
  );

  always #5 clk = ~clk;

  // Issue one command and follow it to done_o; compare against a model
  // computed from the command semantics (latency, serial stream, result).
  task automatic run_cmd(input string nm, input logic [1:0] op, input logic [2:0] cnt,
                         input logic [3:0] data, input logic [7:0] sbits, input int abort_at);
    int L, n_exp, nsh, done_k, w;
    logic [3:0] v, pout_got;
    logic [7:0] so_exp, so_got;
    logic err_exp, err_got;
    logic [1:0] sel_first, sel_exp;
    L = (op == OP_LOAD || op == OP_LOAD_SHR) ? 1 : 0;
    n_exp = (op == OP_LOAD) ? 0 : int'(cnt);
    err_exp = 1'b0;
    if (abort_at > 0 && abort_at <= n_exp) begin n_exp = abort_at; err_exp = 1'b1; end
    v = L ? data : mv;
    so_exp = '0;
    for (int i = 0; i < n_exp; i++) begin
      if (op == OP_SHL) begin so_exp[i] = v[3]; v = (v << 1) | 4'(sbits[i]); end
      else              begin so_exp[i] = v[0]; v = (v >> 1) | (4'(sbits[i]) << 3); end
    end
    sel_exp = L ? 2'b11 : (n_exp == 0 ? 2'b00 : (op == OP_SHL ? 2'b10 : 2'b01));

    @(negedge clk);
    cif.cmd_valid = 1'b1; cif.cmd_op = op; cif.cmd_cnt = cnt; cif.cmd_data = data;
    w = 0;
    while (!cif.cmd_ready && w < 20) begin @(negedge clk); w++; end
    nsh = 0; done_k = -1; so_got = '0; err_got = 1'b0; pout_got = 'x; sel_first = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      cif.cmd_valid = 1'b0;
      if (k == 1) sel_first = sel;
      abort = 1'b0; ser_in = 1'b0;
      if (ser_valid && nsh < 8) begin
        so_got[nsh] = ser_out;
        ser_in = sbits[nsh];
        nsh++;
        if (nsh == abort_at) abort = 1'b1;
      end
      if (done) begin done_k = k; err_got = err; pout_got = pout; break; end
    end
    abort = 1'b0; ser_in = 1'b0;

    n_chk++; if (done_k !== 1 + L + n_exp) begin n_fail++;
      $display("FAIL %s done_cycle got T+%0d exp T+%0d", nm, done_k, 1 + L + n_exp); end
    n_chk++; if (nsh !== n_exp) begin n_fail++;
      $display("FAIL %s shift_cycles got %0d exp %0d", nm, nsh, n_exp); end
    n_chk++; if (so_got !== so_exp) begin n_fail++;
      $display("FAIL %s ser_o_seq got %b exp %b", nm, so_got, so_exp); end
    n_chk++; if (err_got !== err_exp) begin n_fail++;
      $display("FAIL %s err got %b exp %b", nm, err_got, err_exp); end
    n_chk++; if (pout_got !== v) begin n_fail++;
      $display("FAIL %s pout got %h exp %h", nm, pout_got, v); end
    n_chk++; if (sel_first !== sel_exp) begin n_fail++;
      $display("FAIL %s first_sel got %b exp %b", nm, sel_first, sel_exp); end
    mv = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if ({cif.cmd_ready, sel, done, err, ser_valid, pin} !== {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0}) begin
      n_fail++; $display("FAIL reset_outputs got rdy=%b sel=%b done=%b err=%b sv=%b pin=%h",
                         cif.cmd_ready, sel, done, err, ser_valid, pin); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load();
    run_cmd("load_A", OP_LOAD, 3'd0, 4'hA, 8'h00, 0);
  endtask

  task automatic test_load_shr();
    run_cmd("load_shr_B", OP_LOAD_SHR, 3'd4, 4'hB, 8'h00, 0);
  endtask

  task automatic test_shl();
    run_cmd("clear", OP_LOAD, 3'd0, 4'h0, 8'h00, 0);
    run_cmd("shl_in_1011", OP_SHL, 3'd4, 4'h0, 8'b0000_1101, 0);
  endtask

  // cnt=0 SHR with cmd_valid held: accepted at T and again at T+2 only.
  task automatic test_back_to_back();
    logic [3:0] dpat;
    logic       rdy1;
    dpat = '0; rdy1 = 1'bx;
    @(negedge clk);
    cif.cmd_valid = 1'b1; cif.cmd_op = OP_SHR; cif.cmd_cnt = 3'd0; cif.cmd_data = 4'h5;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      dpat[k-1] = done;
      if (k == 1) rdy1 = cif.cmd_ready;
      if (k == 4) cif.cmd_valid = 1'b0;
    end
    n_chk++; if (dpat !== 4'b0101) begin n_fail++;
      $display("FAIL b2b_done_pattern got %b exp 0101", dpat); end
    n_chk++; if (rdy1 !== 1'b0) begin n_fail++;
      $display("FAIL b2b_ready_in_done got %b exp 0", rdy1); end
    repeat (2) @(negedge clk);
    n_chk++; if (pout !== mv) begin n_fail++;
      $display("FAIL b2b_pout_unchanged got %h exp %h", pout, mv); end
  endtask

  task automatic test_abort();
    run_cmd("abort_F", OP_LOAD_SHR, 3'd7, 4'hF, 8'h00, 2);
  endtask

  // LOAD_SHR 9: LOAD at T+1, one shift at T+2, reset during T+3 -> 4'h4 held.
  task automatic test_reset_mid();
    logic dseen;
    @(negedge clk);
    cif.cmd_valid = 1'b1; cif.cmd_op = OP_LOAD_SHR; cif.cmd_cnt = 3'd5; cif.cmd_data = 4'h9;
    ser_in = 1'b0;
    @(negedge clk); cif.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++; if (sel !== 2'b00 || cif.cmd_ready !== 1'b1) begin n_fail++;
      $display("FAIL rst_mid_async got sel=%b rdy=%b exp sel=00 rdy=1", sel, cif.cmd_ready); end
    dseen = 1'b0;
    @(negedge clk); dseen |= done; rst_n = 1'b1;
    repeat (3) begin @(negedge clk); dseen |= done; end
    n_chk++; if (dseen !== 1'b0) begin n_fail++;
      $display("FAIL rst_mid_no_done got %b exp 0", dseen); end
    n_chk++; if (pout !== 4'h4) begin n_fail++;
      $display("FAIL rst_mid_pout_hold got %h exp 4", pout); end
    mv = 4'h4;
    run_cmd("after_reset", OP_LOAD_SHR, 3'd3, 4'h6, 8'b0000_0101, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op; logic [2:0] cnt; logic [3:0] d; logic [7:0] sb; int ab;
      op  = 2'($urandom_range(0, 3));
      cnt = 3'($urandom_range(0, 7));
      d   = 4'($urandom);
      sb  = 8'($urandom);
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      run_cmd($sformatf("rand%0d", i), op, cnt, d, sb, ab);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    cif.cmd_valid = 1'b0; cif.cmd_op = '0; cif.cmd_cnt = '0; cif.cmd_data = '0;
    abort = 1'b0; ser_in = 1'b0; mv = '0;
    test_reset();
    test_load();
    test_load_shr();
    test_shl();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
